wishbone_sram_bridge: RTL and testbench
=======================================

// Module: wishbone_sram_bridge
// PURPOSE
//  Downstream leaf of the Wishbone RAM mux: converts one decoded Wishbone slave port (stb/cyc/we/sel/dat)
//  plus the broadcast bus address into OpenRAM single-port SRAM controls (csb/web/wmask/addr/din).
//  Captures dout after a fixed read latency and returns a one-cycle ack with registered read data.
//  One instance per SRAM macro; ack and dat feed the mux's per-SRAM ack/dat inputs.
// PARAMETERS
//  ADDR_WIDTH    10  SRAM word-address bits; word address = wbs_adr_i[ADDR_WIDTH+1:2]
//  DATA_WIDTH    32  data width; must be 32 (one wmask bit per byte, 4 bits)
//  READ_LATENCY  1   clock edges from the SRAM sampling edge to dout valid; range 1..3
// PORTS
//  wb_clk_i       in   1           Wishbone/SRAM clock; all flops on rising edge
//  wb_rst_ni      in   1           asynchronous, active-low reset
//  wbs_stb_i      in   1           strobe from mux (already gated by select)
//  wbs_cyc_i      in   1           bus cycle valid
//  wbs_we_i       in   1           1 = write, 0 = read
//  wbs_sel_i      in   4           byte selects
//  wbs_dat_i      in   32          write data
//  wbs_adr_i      in   32          broadcast byte address
//  wbs_ack_o      out  1           one-cycle transfer acknowledge
//  wbs_dat_o      out  32          registered read data
//  sram_csb_o     out  1           SRAM chip select, active low
//  sram_web_o     out  1           SRAM write enable, active low
//  sram_wmask_o   out  4           SRAM byte write mask
//  sram_addr_o    out  ADDR_WIDTH  SRAM word address
//  sram_din_o     out  32          SRAM write data
//  sram_dout_i    in   32          SRAM read data
// BEHAVIOUR
//  - Reset (wb_rst_ni=0, async): state=IDLE; wbs_ack_o=0, wbs_dat_o=0, sram_csb_o=1, sram_web_o=1,
//    sram_wmask_o=0, sram_addr_o=0, sram_din_o=0; latency counter=0.
//  - All outputs are registered; no combinational path from any input to any output.
//  - FSM states: IDLE, ACCESS, WAIT, ACK.
//    IDLE:   accept when stb&cyc&!wbs_ack_o at edge E0; register csb=0, web=~we, wmask=we?sel:0, addr, din
//            -> ACCESS.
//    ACCESS: SRAM samples at E1; csb/web return to 1 at E1.
//            Write -> ACK (ack=1 during E1..E2).
//            Read  -> WAIT (counter=READ_LATENCY-1), or straight to capture if READ_LATENCY=1.
//    WAIT:   decrement; at edge E1+READ_LATENCY, wbs_dat_o<=sram_dout_i, ack=1 -> ACK.
//    ACK:    ack high exactly one cycle, then IDLE; a new request is accepted at the next edge with ack=0.
//  - Latency: write ack registered at E1; read ack and data registered at E1+READ_LATENCY
//    (READ_LATENCY=1: ack at E2).
//  - wbs_dat_o holds last read value until next read capture; writes do not modify it.
//  - Write with sel=0: SRAM cycle issued with wmask=0 (no bytes change); still acked.
//  - Abort: cyc=0 in ACCESS/WAIT -> go IDLE, no ack, no dat_o update; an issued SRAM cycle completes harmlessly.
//  - stb deasserted while cyc stays high after accept: transfer completes and acks (no abort).
//  - Address bits above ADDR_WIDTH+1 are ignored (aliasing is resolved by mux decode).
//  - Async reset mid-operation: immediate return to reset values, no ack, csb forced 1.
// CONFIGURATION
//  WB_SRAM_STATS_EN defined: adds outputs stat_rd_cnt_o[15:0] and stat_wr_cnt_o[15:0].
//    Each counts acked reads/writes, saturates at 16'hFFFF, is cleared by reset; aborted transfers are
//    not counted.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 Reset: hold wb_rst_ni=0 -> ack=0, csb=1, web=1, dat_o=0; release -> IDLE, no spurious SRAM access.
//  2 Write adr=0x3000_0010, dat=0xDEADBEEF, sel=4'hF -> at E1 SRAM sees csb=0, web=0, addr=4,
//    wmask=F; ack pulse 1 cycle at E1.
//  3 Read back adr=0x3000_0010 with model dout=0xDEADBEEF, READ_LATENCY=1 and 3
//    -> dat_o=0xDEADBEEF, ack at E2 and E4 respectively.
//  4 Byte write sel=4'b0010, dat=0x0000_AA00 over 0xDEADBEEF -> wmask=0010; readback 0xDEADAAEF.
//  5 Read started then cyc dropped at E1 -> no ack, dat_o unchanged, FSM IDLE; next write acks normally.
//  6 Back-to-back: stb held high across two reads -> second accepted only after ack low;
//    with WB_SRAM_STATS_EN, stat_rd_cnt_o=2, stat_wr_cnt_o=0.

Source files
------------

// File: rtl/wishbone_sram_bridge_if.sv
// Bus bundle between the Wishbone RAM mux leaf port and one OpenRAM single-port macro.
// slave = bridge side, master = mux/SRAM side (used by the bench).
interface wishbone_sram_bridge_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
);
   logic                  wbs_stb_i;
   logic                  wbs_cyc_i;
   logic                  wbs_we_i;
   logic [3:0]            wbs_sel_i;
   logic [DATA_WIDTH-1:0] wbs_dat_i;
   logic [31:0]           wbs_adr_i;
   logic                  wbs_ack_o;
   logic [DATA_WIDTH-1:0] wbs_dat_o;
   logic                  sram_csb_o;
   logic                  sram_web_o;
   logic [3:0]            sram_wmask_o;
   logic [ADDR_WIDTH-1:0] sram_addr_o;
   logic [DATA_WIDTH-1:0] sram_din_o;
   logic [DATA_WIDTH-1:0] sram_dout_i;

   modport slave (
      input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i, sram_dout_i,
      output wbs_ack_o, wbs_dat_o, sram_csb_o, sram_web_o, sram_wmask_o, sram_addr_o, sram_din_o
   );

   modport master (
      output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i, sram_dout_i,
      input  wbs_ack_o, wbs_dat_o, sram_csb_o, sram_web_o, sram_wmask_o, sram_addr_o, sram_din_o
   );
endinterface

// File: rtl/wishbone_sram_bridge.sv
// Wishbone slave leaf -> OpenRAM single-port SRAM bridge; all outputs registered.
// Optional WB_SRAM_STATS_EN adds saturating acked read/write counters.
module wishbone_sram_bridge #(
   parameter int ADDR_WIDTH   = 10,
   parameter int DATA_WIDTH   = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_ni,
`ifdef WB_SRAM_STATS_EN
   output logic [15:0]           stat_rd_cnt_o,
   output logic [15:0]           stat_wr_cnt_o,
`endif
   wishbone_sram_bridge_if.slave bus
);

   if (DATA_WIDTH != 32) begin : g_bad_dw
      $error("wishbone_sram_bridge: DATA_WIDTH must be 32");
   end
   if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_rl
      $error("wishbone_sram_bridge: READ_LATENCY must be 1..3");
   end

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_ACK} state_t;

   state_t                r_state, w_state;
   logic [1:0]            r_cnt, w_cnt;
   logic                  r_ack, w_ack;
   logic [DATA_WIDTH-1:0] r_dat, w_dat;
   logic                  r_csb, w_csb;
   logic                  r_web, w_web;
   logic [3:0]            r_wmask, w_wmask;
   logic [ADDR_WIDTH-1:0] r_addr, w_addr;
   logic [DATA_WIDTH-1:0] r_din, w_din;
   logic                  w_rd_done, w_wr_done;
   logic                  w_unused;

   // Upper address bits alias; decode above this leaf resolves them.
   assign w_unused = ^{bus.wbs_adr_i[31:ADDR_WIDTH+2], bus.wbs_adr_i[1:0]};

   always_comb begin
      w_state   = r_state;
      w_cnt     = r_cnt;
      w_ack     = r_ack;
      w_dat     = r_dat;
      w_csb     = r_csb;
      w_web     = r_web;
      w_wmask   = r_wmask;
      w_addr    = r_addr;
      w_din     = r_din;
      w_rd_done = 1'b0;
      w_wr_done = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.wbs_stb_i && bus.wbs_cyc_i && !r_ack) begin
               w_csb   = 1'b0;
               w_web   = ~bus.wbs_we_i;
               w_wmask = bus.wbs_we_i ? bus.wbs_sel_i : 4'h0;
               w_addr  = bus.wbs_adr_i[ADDR_WIDTH+1:2];
               w_din   = bus.wbs_dat_i;
               w_state = S_ACCESS;
            end
         end
         S_ACCESS: begin
            // SRAM samples this edge; r_web still carries the direction of the transfer.
            w_csb = 1'b1;
            w_web = 1'b1;
            if (!bus.wbs_cyc_i) begin
               w_state = S_IDLE;
            end else if (!r_web) begin
               w_ack     = 1'b1;
               w_wr_done = 1'b1;
               w_state   = S_ACK;
            end else begin
               w_cnt   = 2'(READ_LATENCY - 1);
               w_state = S_WAIT;
            end
         end
         S_WAIT: begin
            if (!bus.wbs_cyc_i) begin
               w_state = S_IDLE;
            end else if (r_cnt == 2'd0) begin
               w_dat     = bus.sram_dout_i;
               w_ack     = 1'b1;
               w_rd_done = 1'b1;
               w_state   = S_ACK;
            end else begin
               w_cnt = r_cnt - 2'd1;
            end
         end
         S_ACK: begin
            w_ack   = 1'b0;
            w_state = S_IDLE;
         end
         default: w_state = S_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_state <= S_IDLE;
         r_cnt   <= 2'd0;
         r_ack   <= 1'b0;
         r_dat   <= '0;
         r_csb   <= 1'b1;
         r_web   <= 1'b1;
         r_wmask <= 4'h0;
         r_addr  <= '0;
         r_din   <= '0;
      end else begin
         r_state <= w_state;
         r_cnt   <= w_cnt;
         r_ack   <= w_ack;
         r_dat   <= w_dat;
         r_csb   <= w_csb;
         r_web   <= w_web;
         r_wmask <= w_wmask;
         r_addr  <= w_addr;
         r_din   <= w_din;
      end
   end

   assign bus.wbs_ack_o    = r_ack;
   assign bus.wbs_dat_o    = r_dat;
   assign bus.sram_csb_o   = r_csb;
   assign bus.sram_web_o   = r_web;
   assign bus.sram_wmask_o = r_wmask;
   assign bus.sram_addr_o  = r_addr;
   assign bus.sram_din_o   = r_din;

`ifdef WB_SRAM_STATS_EN
   logic [15:0] r_rd_cnt, r_wr_cnt;

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_rd_cnt <= 16'h0;
         r_wr_cnt <= 16'h0;
      end else begin
         if (w_rd_done && r_rd_cnt != 16'hFFFF) r_rd_cnt <= r_rd_cnt + 16'h1;
         if (w_wr_done && r_wr_cnt != 16'hFFFF) r_wr_cnt <= r_wr_cnt + 16'h1;
      end
   end

   assign stat_rd_cnt_o = r_rd_cnt;
   assign stat_wr_cnt_o = r_wr_cnt;
`endif

endmodule

// File: tb/tb_wishbone_sram_bridge.sv
// Directed bench: two bridges (READ_LATENCY 1 and 3), each with a byte-masked SRAM model
// whose read data is delayed to match the bridge's configured latency.
module tb_wishbone_sram_bridge;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   wishbone_sram_bridge_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) b1 ();
   wishbone_sram_bridge_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) b3 ();

`ifdef WB_SRAM_STATS_EN
   logic [15:0] s_rd1, s_wr1, s_rd3, s_wr3;
`endif

   wishbone_sram_bridge #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .READ_LATENCY(1)) u_dut1 (
      .wb_clk_i(clk), .wb_rst_ni(rst_n),
`ifdef WB_SRAM_STATS_EN
      .stat_rd_cnt_o(s_rd1), .stat_wr_cnt_o(s_wr1),
`endif
      .bus(b1));

   wishbone_sram_bridge #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .READ_LATENCY(3)) u_dut3 (
      .wb_clk_i(clk), .wb_rst_ni(rst_n),
`ifdef WB_SRAM_STATS_EN
      .stat_rd_cnt_o(s_rd3), .stat_wr_cnt_o(s_wr3),
`endif
      .bus(b3));

   // index 0 drives u_dut1, index 1 drives u_dut3
   logic [1:0]  t_stb = '0, t_cyc = '0, t_we = '0;
   logic [3:0]  t_sel [2];
   logic [31:0] t_dat [2];
   logic [31:0] t_adr [2];

   assign b1.wbs_stb_i = t_stb[0];
   assign b1.wbs_cyc_i = t_cyc[0];
   assign b1.wbs_we_i  = t_we[0];
   assign b1.wbs_sel_i = t_sel[0];
   assign b1.wbs_dat_i = t_dat[0];
   assign b1.wbs_adr_i = t_adr[0];
   assign b3.wbs_stb_i = t_stb[1];
   assign b3.wbs_cyc_i = t_cyc[1];
   assign b3.wbs_we_i  = t_we[1];
   assign b3.wbs_sel_i = t_sel[1];
   assign b3.wbs_dat_i = t_dat[1];
   assign b3.wbs_adr_i = t_adr[1];

   wire [1:0] ack = {b3.wbs_ack_o, b1.wbs_ack_o};
   wire [1:0] csb = {b3.sram_csb_o, b1.sram_csb_o};
   wire [1:0] web = {b3.sram_web_o, b1.sram_web_o};
   logic [31:0] odat  [2];
   logic [31:0] odin  [2];
   logic [3:0]  omask [2];
   logic [9:0]  oaddr [2];
   assign odat[0]  = b1.wbs_dat_o;    assign odat[1]  = b3.wbs_dat_o;
   assign odin[0]  = b1.sram_din_o;   assign odin[1]  = b3.sram_din_o;
   assign omask[0] = b1.sram_wmask_o; assign omask[1] = b3.sram_wmask_o;
   assign oaddr[0] = b1.sram_addr_o;  assign oaddr[1] = b3.sram_addr_o;

   // SRAM models
   logic [31:0] mem1 [1024];
   logic [31:0] mem3 [1024];
   logic [31:0] rp1;
   logic [31:0] rp3 [3];

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                         input logic [3:0] m);
      logic [31:0] r;
      r = old;
      for (int k = 0; k < 4; k++) if (m[k]) r[8*k +: 8] = din[8*k +: 8];
      return r;
   endfunction

   always @(posedge clk) begin
      if (!b1.sram_csb_o) begin
         if (!b1.sram_web_o)
            mem1[b1.sram_addr_o] <= merge(mem1[b1.sram_addr_o], b1.sram_din_o, b1.sram_wmask_o);
         else
            rp1 <= mem1[b1.sram_addr_o];
      end
   end

   always @(posedge clk) begin
      if (!b3.sram_csb_o) begin
         if (!b3.sram_web_o)
            mem3[b3.sram_addr_o] <= merge(mem3[b3.sram_addr_o], b3.sram_din_o, b3.sram_wmask_o);
         else
            rp3[0] <= mem3[b3.sram_addr_o];
      end
      rp3[1] <= rp3[0];
      rp3[2] <= rp3[1];
   end

   assign b1.sram_dout_i = rp1;
   assign b3.sram_dout_i = rp3[2];

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // One complete transfer; lat counts edges from accept (E0=0) to ack seen.
   task automatic xfer(input int d, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input int exp_lat, input logic [31:0] exp_rd,
                       input string tag);
      int lat;
      @(negedge clk);
      t_stb[d] = 1'b1; t_cyc[d] = 1'b1; t_we[d] = we;
      t_adr[d] = adr;  t_dat[d] = dat;  t_sel[d] = sel;
      @(posedge clk); #1;
      chk({tag, "_csb"},   32'(csb[d]),   0);
      chk({tag, "_web"},   32'(web[d]),   32'(!we));
      chk({tag, "_addr"},  32'(oaddr[d]), 32'(adr[11:2]));
      chk({tag, "_wmask"}, 32'(omask[d]), we ? 32'(sel) : 0);
      if (we) chk({tag, "_din"}, odin[d], dat);
      lat = 0;
      while (!ack[d] && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      t_stb[d] = 1'b0; t_cyc[d] = 1'b0;
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_csb_idle"}, 32'(csb[d]), 1);
      if (!we) chk({tag, "_rdat"}, odat[d], exp_rd);
      @(posedge clk); #1;
      chk({tag, "_ack_1cyc"}, 32'(ack[d]), 0);
   endtask

   initial begin
      int acks, lat;
      for (int i = 0; i < 2; i++) begin
         t_sel[i] = 4'h0; t_dat[i] = 32'h0; t_adr[i] = 32'h0;
      end

      // Reset
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ack",   32'(ack[0]),  0);
      chk("rst_csb",   32'(csb[0]),  1);
      chk("rst_web",   32'(web[0]),  1);
      chk("rst_dat",   odat[0],      0);
      chk("rst_wmask", 32'(omask[0]), 0);
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("post_rst_csb", 32'(csb), 32'b11);
      chk("post_rst_ack", 32'(ack), 0);

      // Full-word write, read back on both latencies
      xfer(0, 1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF, 1, 32'h0, "wr1");
      xfer(0, 1'b0, 32'h3000_0010, 32'h0, 4'hF, 2, 32'hDEAD_BEEF, "rd1");
      xfer(1, 1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF, 1, 32'h0, "wr3");
      xfer(1, 1'b0, 32'h3000_0010, 32'h0, 4'hF, 4, 32'hDEAD_BEEF, "rd3");

      // Byte write; dat_o must hold the previous read across writes
      xfer(0, 1'b1, 32'h3000_0010, 32'h0000_AA00, 4'b0010, 1, 32'h0, "bwr");
      chk("dat_hold_wr", odat[0], 32'hDEAD_BEEF);
      xfer(0, 1'b0, 32'h3000_0010, 32'h0, 4'hF, 2, 32'hDEAD_AAEF, "brd");

      // sel=0 write through an aliased address: acked, nothing changes
      xfer(0, 1'b1, 32'h5000_1010, 32'h1234_5678, 4'h0, 1, 32'h0, "sel0");
      xfer(0, 1'b0, 32'h3000_0010, 32'h0, 4'hF, 2, 32'hDEAD_AAEF, "sel0rd");

      // Abort: cyc dropped before E1
      @(negedge clk);
      t_stb[0] = 1'b1; t_cyc[0] = 1'b1; t_we[0] = 1'b0; t_adr[0] = 32'h3000_0010;
      @(negedge clk);
      t_stb[0] = 1'b0; t_cyc[0] = 1'b0;
      acks = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (ack[0]) acks++;
      end
      chk("abort_noack", 32'(acks), 0);
      chk("abort_dat",   odat[0], 32'hDEAD_AAEF);
      chk("abort_csb",   32'(csb[0]), 1);
      xfer(0, 1'b1, 32'h3000_0010, 32'h1122_3344, 4'hF, 1, 32'h0, "abwr");
      xfer(0, 1'b0, 32'h3000_0010, 32'h0, 4'hF, 2, 32'h1122_3344, "abrd");

      // Back-to-back reads with stb held; reset first so stats start from zero
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      t_stb[0] = 1'b1; t_cyc[0] = 1'b1; t_we[0] = 1'b0; t_adr[0] = 32'h3000_0010;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!ack[0] && lat < 10);
      chk("b2b_lat1", 32'(lat), 3);
      chk("b2b_rd1",  odat[0], 32'h1122_3344);
      @(posedge clk); #1;
      chk("b2b_gap_ack", 32'(ack[0]), 0);
      chk("b2b_gap_csb", 32'(csb[0]), 1);
      @(posedge clk); #1;
      chk("b2b_accept2", 32'(csb[0]), 0);
      lat = 0;
      while (!ack[0] && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      t_stb[0] = 1'b0; t_cyc[0] = 1'b0;
      chk("b2b_lat2", 32'(lat), 2);
      chk("b2b_rd2",  odat[0], 32'h1122_3344);
`ifdef WB_SRAM_STATS_EN
      chk("stat_rd", 32'(s_rd1), 2);
      chk("stat_wr", 32'(s_wr1), 0);
`endif
      @(posedge clk); #1;
      chk("b2b_ack_low", 32'(ack[0]), 0);

      // Async reset mid-read on the latency-3 bridge
      @(negedge clk);
      t_stb[1] = 1'b1; t_cyc[1] = 1'b1; t_we[1] = 1'b0; t_adr[1] = 32'h3000_0010;
      @(posedge clk); #1;
      chk("arst_issue", 32'(csb[1]), 0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_csb", 32'(csb[1]), 1);
      chk("arst_ack", 32'(ack[1]), 0);
      chk("arst_dat", odat[1], 0);
      t_stb[1] = 1'b0; t_cyc[1] = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      acks = 0;
      repeat (5) begin
         @(posedge clk); #1;
         if (ack[1]) acks++;
      end
      chk("arst_noack", 32'(acks), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
